// File: rtl/instr_fetch_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master) and imem (slave).
interface instr_fetch_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch / PC sequencer: BOOT -> FETCH -> EXEC loop with a terminal HALT.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned next PC halts instead of being truncated.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         clk,
  input  logic         rst_n,
  instr_fetch_if.master imem,
  input  logic [2:0]   i_pc_imm,
  input  logic         i_op_illegal,
  input  logic         i_alu_zero,
  input  logic [31:0]  i_imm,
  input  logic [31:0]  i_jalr_base,
  output logic [31:0]  o_pc,
  output logic [31:0]  o_instr,
  output logic         o_instr_valid,
  output logic [6:0]   o_op_code,
  output logic [2:0]   o_funct3,
  output logic [6:0]   o_funct7,
  output logic [4:0]   o_rd,
  output logic [4:0]   o_rs1,
  output logic [4:0]   o_rs2,
  output logic         o_halted
);

  localparam logic [2:0] PC_IMM_0    = 3'd0;
  localparam logic [2:0] PC_IMM_4    = 3'd1;
  localparam logic [2:0] PC_IMM_BZ   = 3'd2;
  localparam logic [2:0] PC_IMM_BNZ  = 3'd3;
  localparam logic [2:0] PC_IMM_JAL  = 3'd4;
  localparam logic [2:0] PC_IMM_JALR = 3'd5;

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_EXEC, S_HALT} state_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_pc, w_pc_next;
  logic [31:0] r_ir, w_ir_next;
  logic [31:0] w_pc_plus4, w_pc_rel, w_target, w_next_pc;
  logic        w_advance, w_misalign;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_pc_rel   = r_pc + i_imm;

  always_comb begin
    w_advance = 1'b1;
    w_target  = w_pc_plus4;
    case (i_pc_imm)
      PC_IMM_4:    w_target = w_pc_plus4;
      PC_IMM_BZ:   w_target = i_alu_zero ? w_pc_rel : w_pc_plus4;
      PC_IMM_BNZ:  w_target = i_alu_zero ? w_pc_plus4 : w_pc_rel;
      PC_IMM_JAL:  w_target = w_pc_rel;
      PC_IMM_JALR: w_target = (i_jalr_base + i_imm) & ~32'h1;
      // PC_IMM_0 and unassigned codes hold the current instruction
      default:     w_advance = 1'b0;
    endcase
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  assign w_misalign = (w_target[1:0] != 2'b00);
  assign w_next_pc  = w_target;
`else
  assign w_misalign = 1'b0;
  assign w_next_pc  = w_target & ~32'h3;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_ir    <= NOP_INSTR;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    case (r_state)
      S_BOOT:  w_state_next = S_FETCH;
      S_FETCH: begin
        if (imem.ack) begin
          w_ir_next    = imem.rdata;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (i_op_illegal) begin
          w_state_next = S_HALT;
        end else if (w_advance) begin
          if (w_misalign) begin
            w_state_next = S_HALT;
          end else begin
            w_pc_next    = w_next_pc;
            w_state_next = S_FETCH;
          end
        end
      end
      default: w_state_next = S_HALT;
    endcase
  end

  // Request is a pure decode of state so an async reset drops it immediately
  assign imem.req      = (r_state == S_FETCH);
  assign imem.addr     = r_pc;
  assign o_pc          = r_pc;
  assign o_instr_valid = (r_state == S_EXEC);
  assign o_instr       = o_instr_valid ? r_ir : NOP_INSTR;
  assign o_halted      = (r_state == S_HALT);

  assign o_op_code = o_instr[6:0];
  assign o_rd      = o_instr[11:7];
  assign o_funct3  = o_instr[14:12];
  assign o_rs1     = o_instr[19:15];
  assign o_rs2     = o_instr[24:20];
  assign o_funct7  = o_instr[31:25];

endmodule
